// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core on one shared req/ready memory port.
// Optional perf counters (cycle_cnt, instret_cnt) under `MIPS_MC_PERF_EN.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DBG_REG  = 2,
    parameter int          TEST_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
`ifdef MIPS_MC_PERF_EN
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt,
`endif
    output logic [TEST_W-1:0] test_value
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] target;
    logic [31:0] rf [32];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] br_off;
    logic [31:0] jtarget;
    logic [31:0] alu_r;
    logic        funct_ok;
    logic        retire;
    logic [31:0] next_fetch;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign br_off   = {imm_sext[29:0], 2'b00};
    assign jtarget  = {pc[31:28], ir[25:0], 2'b00};

    assign test_value = rf[DBG_REG][TEST_W-1:0];

    // Word-align a byte address and trim it to the port width.
    function automatic logic [ADDR_W-1:0] align(input logic [31:0] x);
        logic [31:0] t;
        t = {x[31:2], 2'b00};
        return t[ADDR_W-1:0];
    endfunction

    // R-type ALU result and legality of the funct field.
    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        unique case (funct)
            6'h20:   alu_r = a + b;
            6'h22:   alu_r = a - b;
            6'h24:   alu_r = a & b;
            6'h25:   alu_r = a | b;
            6'h2A:   alu_r = {31'b0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    // Instruction completion and the PC of the following fetch.
    always_comb begin
        retire     = 1'b0;
        next_fetch = pc;
        unique case (state)
            S_MEMWB, S_ALUWB, S_ADDIWB: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            S_BRANCH: begin
                retire = 1'b1;
                if (a == b) next_fetch = target;
            end
            S_JUMP: begin
                retire     = 1'b1;
                next_fetch = jtarget;
            end
            default: retire = 1'b0;
        endcase
    end

    // Main FSM: datapath registers, regfile writes and registered memory port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            target    <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= align(pc);
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    target <= pc + br_off;
                    if (op == OP_LW || op == OP_SW) state <= S_MEMADR;
                    else if (op == OP_R && funct_ok) state <= S_EXEC;
                    else if (op == OP_ADDI) state <= S_ADDIEX;
                    else if (op == OP_BEQ) state <= S_BRANCH;
                    else if (op == OP_J) state <= S_JUMP;
                    else begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_MEMADR: begin
                    alu_out  <= a + imm_sext;
                    mem_req  <= 1'b1;
                    mem_addr <= align(a + imm_sext);
                    if (op == OP_SW) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= b;
                        state     <= S_MEMWR;
                    end else begin
                        state <= S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_MEMWB;
                    end
                end
                S_MEMWB: if (rt != 5'd0) rf[rt] <= mdr;
                S_EXEC: begin
                    alu_out <= alu_r;
                    state   <= S_ALUWB;
                end
                S_ALUWB: if (rd != 5'd0) rf[rd] <= alu_out;
                S_ADDIEX: begin
                    alu_out <= a + imm_sext;
                    state   <= S_ADDIWB;
                end
                S_ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
                S_MEMWR, S_BRANCH, S_JUMP, S_HALT: ;
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
            if (retire) begin
                pc       <= next_fetch;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= align(next_fetch);
                state    <= S_FETCH;
            end
        end
    end

`ifdef MIPS_MC_PERF_EN
    // Cycle and retired-instruction counters; both stop once halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
